// File: rtl/seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : seq_detect_param
//  Description : Parametrised serial bit-sequence detector. On each edge with
//                seq_vld high it samples one bit of seq and compares the most
//                recent PAT_W samples against PATTERN. On a match it raises
//                dout for one cycle. Detection can be overlapping or
//                non-overlapping (OVERLAP). An edge with seq_vld low is a
//                bubble: the detector state holds.
//  Options     : define SEQ_DET_MATCH_CNT_EN to build the saturating match
//                counter. Without it, match_cnt is tied to zero.
//  Revision    : 1.0 - initial release
// ============================================================================
module seq_detect_param #(
    parameter int               PAT_W   = 4,
    parameter logic [PAT_W-1:0] PATTERN = 4'b1011,
    parameter bit               OVERLAP = 1'b1,
    parameter int               CNT_W   = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             seq,
    input  logic             seq_vld,
    output logic             dout,
    output logic [CNT_W-1:0] match_cnt
);

    localparam int                c_FILL_W = $clog2(PAT_W + 1);
    localparam logic [c_FILL_W-1:0] c_FULL = c_FILL_W'(PAT_W);

    logic [PAT_W-1:0]    r_hist;
    logic [c_FILL_W-1:0] r_fill;
    logic                r_dout;

    logic [PAT_W-1:0]    w_hist_n;
    logic [c_FILL_W-1:0] w_fill_n;
    logic                w_match_n;

    // Next-state: shift in a qualified bit, count valid bits up to PAT_W, and
    // flag a match only once a full window of qualified bits is present.
    always_comb begin
        w_hist_n  = r_hist;
        w_fill_n  = r_fill;
        w_match_n = 1'b0;
        if (seq_vld) begin
            w_hist_n  = {r_hist[PAT_W-2:0], seq};
            w_fill_n  = (r_fill == c_FULL) ? c_FULL : r_fill + 1'b1;
            w_match_n = (w_fill_n == c_FULL) && (w_hist_n == PATTERN);
        end
    end

    // State register: non-overlapping mode empties the window after a match.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_hist <= '0;
            r_fill <= '0;
            r_dout <= 1'b0;
        end else begin
            r_hist <= w_hist_n;
            r_fill <= (w_match_n && !OVERLAP) ? '0 : w_fill_n;
            r_dout <= w_match_n;
        end
    end

    // Output: registered one-cycle match pulse.
    always_comb begin
        dout = r_dout;
    end

`ifdef SEQ_DET_MATCH_CNT_EN
    localparam logic [CNT_W-1:0] c_CNT_MAX = {CNT_W{1'b1}};

    logic [CNT_W-1:0] r_cnt;

    // Match counter updates on the same edge as dout and sticks at all-ones.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (w_match_n && (r_cnt != c_CNT_MAX)) begin
            r_cnt <= r_cnt + 1'b1;
        end
    end

    // Expose the counter.
    always_comb begin
        match_cnt = r_cnt;
    end
`else
    // Counter not built: port kept, driven to zero.
    always_comb begin
        match_cnt = '0;
    end
`endif

endmodule
`default_nettype wire

// File: tb/tb_seq_detect_param.sv
`default_nettype none
// ============================================================================
//  Module      : tb_seq_detect_param
//  Description : Self-checking bench for seq_detect_param. Four instances with
//                different parameter sets share one stimulus stream. A
//                queue-based reference model predicts every dout and
//                match_cnt value.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_seq_detect_param;

    logic clk;
    logic rst;
    logic seq;
    logic seq_vld;

    logic       d0, d1, d2, d3;
    logic [7:0] c0, c1, c2;
    logic [1:0] c3;

    // Configurations: 0 default, 1 non-overlap, 2 3-bit all-zero, 3 1111 with 2-bit counter
    localparam int CFG_W [4] = '{4, 4, 3, 4};
    localparam int CFG_P [4] = '{'b1011, 'b1011, 'b000, 'b1111};
    localparam int CFG_O [4] = '{1, 0, 1, 1};
    localparam int CFG_M [4] = '{255, 255, 255, 3};

    seq_detect_param u_def (
        .clk(clk), .rst(rst), .seq(seq), .seq_vld(seq_vld), .dout(d0), .match_cnt(c0)
    );
    seq_detect_param #(.OVERLAP(1'b0)) u_novl (
        .clk(clk), .rst(rst), .seq(seq), .seq_vld(seq_vld), .dout(d1), .match_cnt(c1)
    );
    seq_detect_param #(.PAT_W(3), .PATTERN(3'b000)) u_p3 (
        .clk(clk), .rst(rst), .seq(seq), .seq_vld(seq_vld), .dout(d2), .match_cnt(c2)
    );
    seq_detect_param #(.PATTERN(4'b1111), .CNT_W(2)) u_sat (
        .clk(clk), .rst(rst), .seq(seq), .seq_vld(seq_vld), .dout(d3), .match_cnt(c3)
    );

    wire logic [3:0]  dout_v = {d3, d2, d1, d0};
    wire logic [25:0] cnt_v  = {c3, c2, c1, c0};

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    // Reference model state
    bit          bits_q [$];
    int          since [4];
    int          mcount [4];
    logic [3:0]  exp_d;
    logic [25:0] exp_c;

    function automatic logic [25:0] pack_counts();
        logic [25:0] v;
`ifdef SEQ_DET_MATCH_CNT_EN
        v = {2'(mcount[3]), 8'(mcount[2]), 8'(mcount[1]), 8'(mcount[0])};
`else
        v = '0;
`endif
        return v;
    endfunction

    task automatic model_edge(input logic r, input logic v, input logic b);
        exp_d = '0;
        if (r === 1'b1) begin
            bits_q.delete();
            for (int k = 0; k < 4; k++) begin
                since[k]  = 0;
                mcount[k] = 0;
            end
        end else if (v === 1'b1) begin
            bits_q.push_back(b);
            if (bits_q.size() > 32) void'(bits_q.pop_front());
            for (int k = 0; k < 4; k++) begin
                bit hit;
                since[k]++;
                hit = (since[k] >= CFG_W[k]);
                for (int j = 0; j < CFG_W[k]; j++) begin
                    if (hit && bits_q[bits_q.size() - CFG_W[k] + j] != bit'((CFG_P[k] >> (CFG_W[k] - 1 - j)) & 1))
                        hit = 1'b0;
                end
                if (hit) begin
                    exp_d[k] = 1'b1;
                    if (mcount[k] < CFG_M[k]) mcount[k]++;
                    if (CFG_O[k] == 0) since[k] = 0;
                end
            end
        end
        exp_c = pack_counts();
    endtask

    task automatic step(input logic r, input logic v, input logic b);
        @(negedge clk);
        rst = r; seq_vld = v; seq = b;
        @(posedge clk);
        model_edge(r, v, b);
        #1;
    endtask

    task automatic test_reset();
        for (int i = 0; i < 3; i++) begin
            step(1'b1, 1'bx, 1'bx);
            n_chk++;
            if (dout_v !== 4'b0000) $display("FAIL reset_dout cyc%0d got=%b want=0000", i, dout_v);
            else n_pass++;
            n_chk++;
            if (cnt_v !== 26'd0) $display("FAIL reset_cnt cyc%0d got=%h want=0", i, cnt_v);
            else n_pass++;
        end
    endtask

    task automatic test_basic();
        bit s [8] = '{1, 0, 1, 1, 0, 0, 1, 0};
        foreach (s[i]) begin
            step(1'b0, 1'b1, s[i]);
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL basic bit%0d dout got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
            n_chk++;
            if (d0 !== (i == 3)) $display("FAIL basic_direct bit%0d got=%b want=%b", i, d0, (i == 3));
            else n_pass++;
        end
    endtask

    task automatic test_overlap();
        bit s1 [7] = '{1, 0, 1, 1, 0, 1, 1};
        bit s2 [8] = '{1, 0, 1, 1, 1, 0, 1, 1};
        int p_ov = 0;
        int p_no = 0;
        step(1'b1, 1'b0, 1'b0);
        foreach (s1[i]) begin
            step(1'b0, 1'b1, s1[i]);
            p_ov += d0; p_no += d1;
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL overlap_a bit%0d dout got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
        end
        n_chk++;
        if (p_ov != 2 || p_no != 1) $display("FAIL overlap_a_pulses got=%0d/%0d want=2/1", p_ov, p_no);
        else n_pass++;
        step(1'b1, 1'b0, 1'b0);
        p_no = 0;
        foreach (s2[i]) begin
            step(1'b0, 1'b1, s2[i]);
            p_no += d1;
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL overlap_b bit%0d dout got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
        end
        n_chk++;
        if (p_no != 2) $display("FAIL overlap_b_pulses got=%0d want=2", p_no);
        else n_pass++;
    endtask

    task automatic test_bubbles();
        logic v [7] = '{1, 1, 0, 0, 0, 1, 1};
        bit   s [7] = '{1, 0, 1, 1, 1, 1, 1};
        step(1'b1, 1'b0, 1'b0);
        foreach (s[i]) begin
            step(1'b0, v[i], s[i]);
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL bubble step%0d dout got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
        end
        n_chk++;
        if (d0 !== 1'b1) $display("FAIL bubble_final got=%b want=1", d0);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        logic r [8] = '{0, 0, 0, 1, 0, 0, 0, 0};
        bit   s [8] = '{1, 0, 1, 1, 1, 0, 1, 1};
        foreach (s[i]) begin
            step(r[i], 1'b1, s[i]);
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL reset_mid step%0d dout got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
            n_chk++;
            if (cnt_v !== exp_c) $display("FAIL reset_mid_cnt step%0d got=%h want=%h", i, cnt_v, exp_c);
            else n_pass++;
        end
    endtask

    task automatic test_fill_gate();
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            step(1'b0, 1'b1, 1'b0);
            n_chk++;
            if (d2 !== (i >= 2)) $display("FAIL fill_gate bit%0d got=%b want=%b", i, d2, (i >= 2));
            else n_pass++;
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL fill_gate_all bit%0d got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
        end
    endtask

    task automatic test_saturate();
        int pulses = 0;
        step(1'b1, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) begin
            step(1'b0, 1'b1, 1'b1);
            pulses += d3;
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL saturate bit%0d dout got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
            n_chk++;
            if (cnt_v !== exp_c) $display("FAIL saturate_cnt bit%0d got=%h want=%h", i, cnt_v, exp_c);
            else n_pass++;
        end
        n_chk++;
        if (pulses != 6) $display("FAIL saturate_pulses got=%0d want=6", pulses);
        else n_pass++;
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            logic r, v, b;
            r = ($urandom_range(99) < 2);
            v = ($urandom_range(99) < 75);
            b = ($urandom_range(99) < 60);
            step(r, v, b);
            n_chk++;
            if (dout_v !== exp_d) $display("FAIL random cyc%0d dout got=%b want=%b", i, dout_v, exp_d);
            else n_pass++;
            n_chk++;
            if (cnt_v !== exp_c) $display("FAIL random_cnt cyc%0d got=%h want=%h", i, cnt_v, exp_c);
            else n_pass++;
        end
    endtask

    initial begin
        rst     = 1'b1;
        seq     = 1'bx;
        seq_vld = 1'bx;
        exp_d   = '0;
        exp_c   = '0;
        foreach (since[k]) begin
            since[k]  = 0;
            mcount[k] = 0;
        end
        test_reset();
        test_basic();
        test_overlap();
        test_bubbles();
        test_reset_mid();
        test_fill_gate();
        test_saturate();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
